// File: rtl/rro_exp2_recon.sv
// Output-side range reconstruction for the exp2 SFU path: buffers range-reduced words,
// pairs each in order with its 2^frac polynomial result and emits an IEEE754 single.
module rro_exp2_recon #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rro_valid,
    output logic                         rro_ready,
    input  logic [31:0]                  rro_data,
    input  logic                         poly_valid,
    output logic                         poly_ready,
    input  logic [23:0]                  poly_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic [2:0]                   out_flags,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    localparam logic [2:0] FLAG_NONE = 3'b000;
    localparam logic [2:0] FLAG_FTZ  = 3'b001;
    localparam logic [2:0] FLAG_INF  = 3'b010;
    localparam logic [2:0] FLAG_NAN  = 3'b100;

    typedef enum logic [7:0] {
        CODE_ONE  = 8'h00,
        CODE_INF  = 8'h0F,
        CODE_ZERO = 8'hF0,
        CODE_NAN  = 8'hFF
    } special_code_e;

    logic [31:0]             mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [31:0]             head;
    logic signed [9:0]       exp_biased;
    logic [31:0]             res_data;
    logic [2:0]              res_flags;
    logic                    unused_bits;

    assign full       = (count == LVL_W'(DEPTH));
    assign empty      = (count == '0);
    assign rro_ready  = !full;
    assign poly_ready = !empty && (!out_valid || out_ready);
    assign push       = rro_valid && rro_ready;
    assign pop        = poly_valid && poly_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = count;

    // Fraction of the reduced word is consumed by the polynomial, not here; bit 22 of a
    // NaN code is forced to 1 (quiet) and poly_data[23] is the implied leading one.
    assign unused_bits = ^{head[22], poly_data[23]};

    // NOTE: storage carries no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rro_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Unbiased integer part sign-extended to 10 bits so i=-128 cannot wrap into a valid exponent.
    assign exp_biased = $signed({{2{head[30]}}, head[30:23]}) + 10'sd127;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        res_data  = 32'h0000_0000;
        res_flags = FLAG_NONE;
        if (!head[31]) begin
            if (exp_biased >= 10'sd1) begin
                res_data = {1'b0, exp_biased[7:0], poly_data[22:0]};
            end else begin
                res_flags = FLAG_FTZ;
            end
        end else begin
            case (head[30:23])
                CODE_INF: begin
                    res_data  = 32'h7F80_0000;
                    res_flags = FLAG_INF;
                end
                CODE_ZERO: begin
                    res_data  = 32'h0000_0000;
                    res_flags = FLAG_FTZ;
                end
                CODE_ONE: begin
                    res_data  = 32'h3F80_0000;
                    res_flags = FLAG_NONE;
                end
                CODE_NAN: begin
                    res_data  = {9'h0FF, 1'b1, head[21:0]};
                    res_flags = FLAG_NAN;
                end
                default: begin
                    res_data  = 32'h7FC0_0000;
                    res_flags = FLAG_NAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_flags <= res_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
